// File: rtl/coverfloat_vector_sequencer.sv
// Plays packed cover vectors from a read-latency-1 memory to a valid/ready consumer.
// Optional COVERFLOAT_STALL_COUNT_EN adds a saturating consumer-stall counter (stall_cycles).
module coverfloat_vector_sequencer #(
    parameter int unsigned VEC_W  = 512,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] num_vectors,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [VEC_W-1:0]  mem_rd_data,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [VEC_W-1:0]  vec_data,
    output logic              sample_strobe,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vec_count
`ifdef COVERFLOAT_STALL_COUNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_mem_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_vec_valid;
    logic [VEC_W-1:0]  r_vec_data;
    logic              r_sample_strobe;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_vec_count;
    logic [ADDR_W-1:0] r_num;

    logic              w_start_ok;
    logic [ADDR_W-1:0] w_count_inc;
    logic              w_last;

    // start+abort together in IDLE is a no-op; abort is meaningless in DONE
    assign w_start_ok  = start && ((r_state == DONE) || ((r_state == IDLE) && !abort));
    assign w_count_inc = r_vec_count + ADDR_W'(1);
    assign w_last      = (w_count_inc == r_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_mem_rd_en     <= 1'b0;
            r_mem_addr      <= '0;
            r_vec_valid     <= 1'b0;
            r_vec_data      <= '0;
            r_sample_strobe <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_vec_count     <= '0;
            r_num           <= '0;
        end else begin
            r_sample_strobe <= 1'b0;
            r_mem_rd_en     <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_num       <= num_vectors;
                        r_mem_addr  <= '0;
                        r_vec_count <= '0;
                        if (num_vectors == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= FETCH;
                            r_mem_rd_en <= 1'b1;
                            r_done      <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_vec_data  <= mem_rd_data;
                        r_vec_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (abort) begin
                        r_state     <= IDLE;
                        r_vec_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (vec_ready) begin
                        r_vec_valid     <= 1'b0;
                        r_sample_strobe <= 1'b1;
                        r_vec_count     <= w_count_inc;
                        r_mem_addr      <= r_mem_addr + ADDR_W'(1);
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= FETCH;
                            r_mem_rd_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_vec_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef COVERFLOAT_STALL_COUNT_EN
    logic [31:0] r_stall_cycles;

    // Cycles the consumer held off a presented vector, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_start_ok) begin
            r_stall_cycles <= '0;
        end else if ((r_state == PRESENT) && !vec_ready && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign mem_rd_en     = r_mem_rd_en;
    assign mem_addr      = r_mem_addr;
    assign vec_valid     = r_vec_valid;
    assign vec_data      = r_vec_data;
    assign sample_strobe = r_sample_strobe;
    assign busy          = r_busy;
    assign done          = r_done;
    assign vec_count     = r_vec_count;

endmodule
